// File: rtl/bus_dma_copy.sv
// Word-copy DMA: a register slave programmed by the core, plus a bus initiator
// that moves LEN words from SRC to DST and raises a level interrupt when done.
module bus_dma_copy #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int LenWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 dev_req_i,
  input  logic                 dev_we_i,
  input  logic [3:0]           dev_be_i,
  input  logic [AddrWidth-1:0] dev_addr_i,
  input  logic [DataWidth-1:0] dev_wdata_i,
  output logic                 dev_rvalid_o,
  output logic [DataWidth-1:0] dev_rdata_o,
  output logic                 dev_err_o,
  output logic                 host_req_o,
  input  logic                 host_gnt_i,
  output logic [AddrWidth-1:0] host_addr_o,
  output logic                 host_we_o,
  output logic [3:0]           host_be_o,
  output logic [DataWidth-1:0] host_wdata_o,
  input  logic                 host_rvalid_i,
  input  logic [DataWidth-1:0] host_rdata_i,
  input  logic                 host_err_i,
  output logic                 irq_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] WR_WAIT = 3'd4;

  logic [2:0]           state, state_d;
  logic [AddrWidth-1:0] src, dst;
  logic [LenWidth-1:0]  len;
  logic [DataWidth-1:0] data_q;
  logic                 irq_en, done, err;

  logic [2:0] offs;
  logic       busy, wr_full, ctrl_wr, stat_wr, start;
  logic       wr_src, wr_dst, wr_len;
  logic       rsp, abort, word_done, last_word;
  logic       irq_en_d, done_d, err_d;
  logic       dev_err_d;
  logic [DataWidth-1:0] dev_rdata_d;
  logic       unused_addr;

  // Only bits [4:2] select a register; the bus decoder handles the rest.
  assign offs        = dev_addr_i[4:2];
  assign unused_addr = ^{dev_addr_i[AddrWidth-1:5], dev_addr_i[1:0]};

  assign busy    = (state != IDLE);
  assign wr_full = dev_req_i & dev_we_i & (dev_be_i == 4'hF);
  assign wr_src  = wr_full & (offs == 3'd0) & ~busy;
  assign wr_dst  = wr_full & (offs == 3'd1) & ~busy;
  assign wr_len  = wr_full & (offs == 3'd2) & ~busy;
  assign ctrl_wr = wr_full & (offs == 3'd3);
  assign stat_wr = wr_full & (offs == 3'd4);
  assign start   = ctrl_wr & dev_wdata_i[0] & ~busy;

  assign rsp       = host_rvalid_i & ((state == RD_WAIT) | (state == WR_WAIT));
  assign abort     = rsp & host_err_i;
  assign word_done = rsp & ~host_err_i & (state == WR_WAIT);
  assign last_word = word_done & (len == LenWidth'(1));

  // Hardware set of DONE takes priority over a same-cycle W1C.
  assign irq_en_d = ctrl_wr ? dev_wdata_i[1] : irq_en;
  assign done_d   = (start & (len == '0)) | last_word | abort |
                    (done & ~(stat_wr & dev_wdata_i[1]));
  assign err_d    = abort | (err & ~(stat_wr & dev_wdata_i[2]));

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start && len != '0) state_d = RD_REQ;
      RD_REQ:  if (host_gnt_i) state_d = RD_WAIT;
      RD_WAIT: if (host_rvalid_i) state_d = host_err_i ? IDLE : WR_REQ;
      WR_REQ:  if (host_gnt_i) state_d = WR_WAIT;
      WR_WAIT: if (host_rvalid_i)
                 state_d = (host_err_i || len == LenWidth'(1)) ? IDLE : RD_REQ;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dev_err_d   = dev_req_i & ((offs > 3'd4) | (dev_we_i & busy & (offs <= 3'd2)));
    dev_rdata_d = '0;
    if (dev_req_i && !dev_we_i) begin
      case (offs)
        3'd0:    dev_rdata_d = DataWidth'({src[AddrWidth-1:2], 2'b00});
        3'd1:    dev_rdata_d = DataWidth'({dst[AddrWidth-1:2], 2'b00});
        3'd2:    dev_rdata_d = DataWidth'(len);
        3'd3:    dev_rdata_d = DataWidth'({irq_en, 1'b0});
        3'd4:    dev_rdata_d = DataWidth'({err, done, busy});
        default: dev_rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      src          <= '0;
      dst          <= '0;
      len          <= '0;
      data_q       <= '0;
      irq_en       <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      irq_o        <= 1'b0;
      dev_rvalid_o <= 1'b0;
      dev_rdata_o  <= '0;
      dev_err_o    <= 1'b0;
    end else begin
      state        <= state_d;
      irq_en       <= irq_en_d;
      done         <= done_d;
      err          <= err_d;
      irq_o        <= done_d & irq_en_d;
      dev_rvalid_o <= dev_req_i;
      dev_rdata_o  <= dev_rdata_d;
      dev_err_o    <= dev_err_d;
      if (state == RD_WAIT && host_rvalid_i) data_q <= host_rdata_i;
      if (wr_src) src <= AddrWidth'(dev_wdata_i);
      else if (word_done) src <= src + AddrWidth'(4);
      if (wr_dst) dst <= AddrWidth'(dev_wdata_i);
      else if (word_done) dst <= dst + AddrWidth'(4);
      if (wr_len) len <= dev_wdata_i[LenWidth-1:0];
      else if (word_done) len <= len - LenWidth'(1);
    end
  end

  // Host outputs decode straight from state so reset drops the request at once.
  assign host_req_o   = (state == RD_REQ) | (state == WR_REQ);
  assign host_we_o    = (state == WR_REQ);
  assign host_be_o    = {4{host_req_o}};
  assign host_addr_o  = (state == RD_REQ) ? {src[AddrWidth-1:2], 2'b00} :
                        (state == WR_REQ) ? {dst[AddrWidth-1:2], 2'b00} : '0;
  assign host_wdata_o = (state == WR_REQ) ? data_q : '0;

endmodule

// File: tb/tb_bus_dma_copy.sv
// Directed bench for bus_dma_copy: register access, copies, stalls, bus errors,
// busy-write protection, DONE set/clear collision and reset mid-transfer.
module tb_bus_dma_copy;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        dev_req_i = 1'b0, dev_we_i = 1'b0;
  logic [3:0]  dev_be_i = 4'h0;
  logic [31:0] dev_addr_i = '0, dev_wdata_i = '0;
  logic        dev_rvalid_o, dev_err_o;
  logic [31:0] dev_rdata_o;
  logic        host_req_o, host_gnt_i = 1'b0, host_we_o;
  logic [31:0] host_addr_o, host_wdata_o;
  logic [3:0]  host_be_o;
  logic        host_rvalid_i = 1'b0, host_err_i = 1'b0;
  logic [31:0] host_rdata_i = '0;
  logic        irq_o;

  bus_dma_copy dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dev_req_i(dev_req_i), .dev_we_i(dev_we_i), .dev_be_i(dev_be_i),
    .dev_addr_i(dev_addr_i), .dev_wdata_i(dev_wdata_i),
    .dev_rvalid_o(dev_rvalid_o), .dev_rdata_o(dev_rdata_o), .dev_err_o(dev_err_o),
    .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_addr_o(host_addr_o),
    .host_we_o(host_we_o), .host_be_o(host_be_o), .host_wdata_o(host_wdata_o),
    .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i), .host_err_i(host_err_i),
    .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0, checks = 0;

  // Bus memory model and responder controls
  logic [31:0] mem [logic [31:0]];
  int   max_stall = 0, err_rd_at = -1, inject_req = 0;
  logic hold_all = 1'b0, hold_wr = 1'b0;
  int   rd_cnt = 0, wr_cnt = 0, order_err = 0, req_cycles = 0;
  int   stab_errs = 0, stab_chk = 0;

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hA000_0000 ^ (a * 32'd7);
  endfunction

  // Responder: drives grant/response at negedge for the following posedge.
  initial begin : responder
    int   stall_cnt, inject_done;
    logic resp_pend, resp_err, prev_wait, last_we, s_we;
    logic [31:0] resp_data, s_addr, s_wdata;
    stall_cnt = 0; inject_done = 0; resp_pend = 0; resp_err = 0;
    prev_wait = 0; last_we = 1; s_we = 0; resp_data = 0; s_addr = 0; s_wdata = 0;
    forever begin
      @(negedge clk_i);
      host_gnt_i = 0; host_rvalid_i = 0; host_err_i = 0; host_rdata_i = '0;
      if (prev_wait) begin
        stab_chk++;
        if (!host_req_o || host_addr_o !== s_addr || host_we_o !== s_we ||
            host_wdata_o !== s_wdata) stab_errs++;
      end
      prev_wait = 0;
      if (rst_i) resp_pend = 0;
      else if (inject_req != inject_done) begin
        inject_done++; host_rvalid_i = 1; host_rdata_i = 32'hDEAD_BEEF;
      end else if (resp_pend) begin
        host_rvalid_i = 1; host_rdata_i = resp_data; host_err_i = resp_err; resp_pend = 0;
      end else if (host_req_o) begin
        req_cycles++;
        if (hold_all || (hold_wr && host_we_o) || (max_stall != 0 && stall_cnt != 0)) begin
          if (stall_cnt != 0) stall_cnt--;
          prev_wait = 1; s_addr = host_addr_o; s_we = host_we_o; s_wdata = host_wdata_o;
        end else begin
          host_gnt_i = 1;
          stall_cnt = $urandom_range(max_stall, 0);
          if (host_we_o) begin
            wr_cnt++; mem[host_addr_o] = host_wdata_o;
            if (last_we) order_err++;
            last_we = 1; resp_data = 0; resp_err = 0;
          end else begin
            resp_err = (rd_cnt == err_rd_at); rd_cnt++;
            resp_data = mrd(host_addr_o);
            if (!last_we) order_err++;
            last_we = 0;
          end
          resp_pend = 1;
        end
      end
    end
  end

  logic [31:0] rd_v;
  logic        er_v, rv_v;

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk_i);
    dev_req_i = 1; dev_we_i = 1; dev_be_i = 4'hF; dev_addr_i = {27'h0, a}; dev_wdata_i = d;
    @(negedge clk_i);
    dev_req_i = 0; dev_we_i = 0; rv_v = dev_rvalid_o; er_v = dev_err_o; rd_v = dev_rdata_o;
  endtask

  task automatic rd(input logic [4:0] a);
    @(negedge clk_i);
    dev_req_i = 1; dev_we_i = 0; dev_be_i = 4'hF; dev_addr_i = {27'h0, a}; dev_wdata_i = '0;
    @(negedge clk_i);
    dev_req_i = 0; rv_v = dev_rvalid_o; er_v = dev_err_o; rd_v = dev_rdata_o;
  endtask

  task automatic wait_idle(output logic to);
    to = 1;
    for (int i = 0; i < 400; i++) begin
      rd(5'h10);
      if (!rd_v[0]) begin to = 0; break; end
    end
  endtask

  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
    wr(5'h00, s); wr(5'h04, d); wr(5'h08, n); wr(5'h0C, 32'h1);
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({host_req_o, host_we_o, host_be_o, irq_o, dev_rvalid_o, dev_err_o} !== 9'h0 ||
        host_addr_o !== 0 || host_wdata_o !== 0 || dev_rdata_o !== 0) begin
      errors++; $display("FAIL reset_outputs: got req=%b addr=%h irq=%b rv=%b want all 0",
                         host_req_o, host_addr_o, irq_o, dev_rvalid_o);
    end
    rst_i = 0;
    for (int o = 0; o < 5; o++) begin
      rd(5'(o * 4));
      checks++;
      if (rd_v !== 32'h0 || er_v !== 1'b0 || rv_v !== 1'b1) begin
        errors++; $display("FAIL reset_reg%0d: got %h err=%b rv=%b want 0 err=0 rv=1",
                           o, rd_v, er_v, rv_v);
      end
    end
    exp = 32'h0;
    rd(5'h14);
    checks++;
    if (rd_v !== exp || er_v !== 1'b1) begin
      errors++; $display("FAIL bad_offset: got %h err=%b want 0 err=1", rd_v, er_v);
    end
    wr(5'h00, 32'h1234_5677);
    rd(5'h00);
    checks++;
    if (rd_v !== 32'h1234_5674) begin
      errors++; $display("FAIL src_lowbits: got %h want 12345674", rd_v);
    end
  endtask

  task automatic test_basic_copy();
    int br, bw, bo; logic to;
    br = rd_cnt; bw = wr_cnt; bo = order_err;
    for (int i = 0; i < 4; i++) mem[32'h100000 + 4*i] = pat(32'h100000 + 4*i);
    start_copy(32'h100000, 32'h100400, 4);
    wait_idle(to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_timeout: got busy want idle"); end
    checks++;
    if (rd_cnt - br != 4 || wr_cnt - bw != 4 || order_err != bo) begin
      errors++; $display("FAIL basic_txns: got rd=%0d wr=%0d order_err=%0d want 4 4 0",
                         rd_cnt - br, wr_cnt - bw, order_err - bo);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mrd(32'h100400 + 4*i) !== pat(32'h100000 + 4*i)) begin
        errors++; $display("FAIL basic_word%0d: got %h want %h", i,
                           mrd(32'h100400 + 4*i), pat(32'h100000 + 4*i));
      end
    end
    rd(5'h00); checks++;
    if (rd_v !== 32'h100010) begin errors++; $display("FAIL basic_src: got %h want 00100010", rd_v); end
    rd(5'h04); checks++;
    if (rd_v !== 32'h100410) begin errors++; $display("FAIL basic_dst: got %h want 00100410", rd_v); end
    rd(5'h08); checks++;
    if (rd_v !== 32'h0) begin errors++; $display("FAIL basic_len: got %h want 0", rd_v); end
    rd(5'h10); checks++;
    if (rd_v !== 32'h2) begin errors++; $display("FAIL basic_status: got %h want 2", rd_v); end
    wr(5'h10, 32'h2); rd(5'h10); checks++;
    if (rd_v !== 32'h0) begin errors++; $display("FAIL basic_w1c: got %h want 0", rd_v); end
  endtask

  task automatic test_zero_len();
    int rc;
    rc = req_cycles;
    wr(5'h08, 32'h0);
    wr(5'h0C, 32'h3);
    checks++;
    if (er_v !== 1'b0) begin errors++; $display("FAIL zlen_err: got %b want 0", er_v); end
    @(negedge clk_i); checks++;
    if (irq_o !== 1'b1) begin errors++; $display("FAIL zlen_irq: got %b want 1", irq_o); end
    rd(5'h10); checks++;
    if (rd_v !== 32'h2 || req_cycles != rc) begin
      errors++; $display("FAIL zlen_status: got %h reqs=%0d want 2 reqs=0", rd_v, req_cycles - rc);
    end
    wr(5'h10, 32'h2);
    @(negedge clk_i); checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL zlen_irq_clr: got %b want 0", irq_o); end
    wr(5'h0C, 32'h0);
  endtask

  task automatic test_stalls();
    int se, sc; logic to;
    se = stab_errs; sc = stab_chk;
    for (int i = 0; i < 8; i++) mem[32'h200000 + 4*i] = pat(32'h200000 + 4*i);
    max_stall = 5;
    start_copy(32'h200000, 32'h200800, 8);
    wait_idle(to);
    max_stall = 0;
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL stall_timeout: got busy want idle"); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mrd(32'h200800 + 4*i) !== pat(32'h200000 + 4*i)) begin
        errors++; $display("FAIL stall_word%0d: got %h want %h", i,
                           mrd(32'h200800 + 4*i), pat(32'h200000 + 4*i));
      end
    end
    checks++;
    if (stab_errs != se || stab_chk == sc) begin
      errors++; $display("FAIL stall_stable: got unstable=%0d stalled=%0d want 0 and >0",
                         stab_errs - se, stab_chk - sc);
    end
    wr(5'h10, 32'h2);
  endtask

  task automatic test_bus_error();
    logic to;
    for (int i = 0; i < 5; i++) begin
      mem[32'h300000 + 4*i] = pat(32'h300000 + 4*i);
      mem[32'h300400 + 4*i] = 32'hFFFF_FFFF;
    end
    err_rd_at = rd_cnt + 2;
    start_copy(32'h300000, 32'h300400, 5);
    wait_idle(to);
    err_rd_at = -1;
    checks++;
    if (to !== 1'b0 || rd_v !== 32'h6) begin
      errors++; $display("FAIL err_status: got %h to=%b want 6", rd_v, to);
    end
    rd(5'h00); checks++;
    if (rd_v !== 32'h300008) begin errors++; $display("FAIL err_src: got %h want 00300008", rd_v); end
    rd(5'h04); checks++;
    if (rd_v !== 32'h300408) begin errors++; $display("FAIL err_dst: got %h want 00300408", rd_v); end
    rd(5'h08); checks++;
    if (rd_v !== 32'h3) begin errors++; $display("FAIL err_len: got %h want 3", rd_v); end
    checks++;
    if (mrd(32'h300408) !== 32'hFFFF_FFFF || mrd(32'h300404) !== pat(32'h300004)) begin
      errors++; $display("FAIL err_mem: got w2=%h w1=%h want ffffffff %h",
                         mrd(32'h300408), mrd(32'h300404), pat(32'h300004));
    end
    wr(5'h10, 32'h6); rd(5'h10); checks++;
    if (rd_v !== 32'h0) begin errors++; $display("FAIL err_w1c: got %h want 0", rd_v); end
  endtask

  task automatic test_busy_write();
    logic to;
    hold_all = 1;
    start_copy(32'h400000, 32'h400400, 8);
    rd(5'h10); checks++;
    if (rd_v !== 32'h1) begin errors++; $display("FAIL busy_status: got %h want 1", rd_v); end
    wr(5'h08, 32'h55); checks++;
    if (er_v !== 1'b1) begin errors++; $display("FAIL busy_len_err: got %b want 1", er_v); end
    rd(5'h08); checks++;
    if (rd_v !== 32'h8) begin errors++; $display("FAIL busy_len_keep: got %h want 8", rd_v); end
    wr(5'h0C, 32'h1); checks++;
    if (er_v !== 1'b0) begin errors++; $display("FAIL busy_start_err: got %b want 0", er_v); end
    hold_all = 0;
    wait_idle(to);
    rd(5'h08); checks++;
    if (to !== 1'b0 || rd_v !== 32'h0) begin
      errors++; $display("FAIL busy_finish: got len=%h to=%b want 0", rd_v, to);
    end
    wr(5'h10, 32'h2);
    // Single word: with zero-wait responses DONE is set at the 4th edge after START.
    mem[32'h500000] = 32'h1234_5678;
    wr(5'h00, 32'h500000); wr(5'h04, 32'h500400); wr(5'h08, 32'h1);
    wr(5'h0C, 32'h1);
    repeat (2) @(negedge clk_i);
    wr(5'h10, 32'h2);
    rd(5'h10); checks++;
    if (rd_v !== 32'h2) begin errors++; $display("FAIL done_set_wins: got %h want 2", rd_v); end
    checks++;
    if (mrd(32'h500400) !== 32'h1234_5678) begin
      errors++; $display("FAIL single_word: got %h want 12345678", mrd(32'h500400));
    end
    wr(5'h10, 32'h2);
  endtask

  task automatic test_reset_mid();
    logic found;
    found = 0;
    hold_wr = 1;
    mem[32'h600000] = 32'hCAFE_0001;
    wr(5'h0C, 32'h2);
    start_copy(32'h600000, 32'h600400, 2);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (host_req_o && host_we_o) begin found = 1; break; end
    end
    checks++;
    if (found !== 1'b1) begin errors++; $display("FAIL rst_wrreq: got no WR_REQ want WR_REQ"); end
    rst_i = 1;
    #1;
    checks++;
    if (host_req_o !== 1'b0 || host_addr_o !== 0 || host_we_o !== 1'b0) begin
      errors++; $display("FAIL rst_async_req: got req=%b addr=%h want 0", host_req_o, host_addr_o);
    end
    repeat (2) @(negedge clk_i);
    rst_i = 0; hold_wr = 0;
    inject_req++;
    repeat (3) @(negedge clk_i);
    checks++;
    if (host_req_o !== 1'b0 || irq_o !== 1'b0) begin
      errors++; $display("FAIL rst_late_rvalid: got req=%b irq=%b want 0 0", host_req_o, irq_o);
    end
    for (int o = 0; o < 5; o++) begin
      rd(5'(o * 4)); checks++;
      if (rd_v !== 32'h0) begin errors++; $display("FAIL rst_reg%0d: got %h want 0", o, rd_v); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_zero_len();
    test_stalls();
    test_bus_error();
    test_busy_write();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion want finish before 400000");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/bus_dma_copy.md
Name: bus_dma_copy

Overview:
- Word-copy DMA engine for the simple system bus.
- Sits on the bus as a device, where the core programs its registers.
- Also sits on the bus as a second host (initiator), issuing read/write pairs to move LEN 32-bit words from SRC to DST.
- Raises a level interrupt on completion, suitable for the core's fast IRQ inputs.

Parameters:
- AddrWidth, 32, width of bus addresses on both ports.
- DataWidth, 32, width of bus data; only 32 is supported.
- LenWidth, 16, width of the word-count register.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- dev_req_i  in  1  register access request, single-cycle, no grant
- dev_we_i  in  1  register write enable
- dev_be_i  in  4  byte enables; only 4'b1111 writes take effect
- dev_addr_i  in  AddrWidth  register address; offset is bits [4:2]
- dev_wdata_i  in  DataWidth  register write data
- dev_rvalid_o  out  1  response valid, one cycle after dev_req_i
- dev_rdata_o  out  DataWidth  read data, valid with dev_rvalid_o
- dev_err_o  out  1  access error, valid with dev_rvalid_o
- host_req_o  out  1  bus request
- host_gnt_i  in  1  bus grant
- host_addr_o  out  AddrWidth  bus address, word aligned
- host_we_o  out  1  bus write enable
- host_be_o  out  4  bus byte enables, always 4'b1111
- host_wdata_o  out  DataWidth  bus write data
- host_rvalid_i  in  1  bus response valid
- host_rdata_i  in  DataWidth  bus read data
- host_err_i  in  1  bus error, qualified by host_rvalid_i
- irq_o  out  1  completion interrupt, level

Behaviour:
- Reset: all outputs 0. SRC, DST, LEN, CTRL and STATUS are 0. FSM is in IDLE.
- Register map:
  - 0x00 SRC: rw, bits [1:0] read 0.
  - 0x04 DST: rw, bits [1:0] read 0.
  - 0x08 LEN: rw, zero-extended to 32 bits.
  - 0x0C CTRL: bit0 START (write 1 to start, reads 0); bit1 IRQ_EN (rw).
  - 0x10 STATUS: bit0 BUSY (ro); bit1 DONE (sticky, write 1 to clear); bit2 ERR (sticky, write 1 to clear).
  - Other offsets: err=1, rdata=0.
- Register access:
  - dev_rvalid_o is asserted exactly one cycle after each dev_req_i.
  - Writes to SRC, DST or LEN while BUSY are dropped with err=1.
  - START while BUSY is ignored with err=0.
  - Reads while BUSY return the live working values.
- Working registers: SRC and DST advance by 4 after each completed word, wrapping modulo 2^AddrWidth. LEN decrements by 1 per completed word.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
  - IDLE: on START, if LEN==0, set DONE the same cycle and stay IDLE. Otherwise set BUSY and go to RD_REQ.
  - RD_REQ: host_req_o=1, we=0, addr=SRC. On host_gnt_i go to RD_WAIT.
  - RD_WAIT: on host_rvalid_i, capture rdata into the data buffer. If host_err_i, go to abort. Otherwise go to WR_REQ.
  - WR_REQ: host_req_o=1, we=1, addr=DST, wdata=buffer. On host_gnt_i go to WR_WAIT.
  - WR_WAIT: on host_rvalid_i, if host_err_i go to abort. Otherwise update the working registers, then go to RD_REQ if the new LEN != 0, else clear BUSY, set DONE and go to IDLE.
  - Abort: set ERR and DONE, clear BUSY, go to IDLE. SRC, DST and LEN stay at the failing word.
- Bus handshake:
  - host_req_o, addr, we and wdata are held stable from assertion until the grant cycle.
  - host_req_o is deasserted in the cycle after the grant.
  - At most one transaction is outstanding.
  - A grant in the same cycle as req assertion is legal.
  - host_rvalid_i is ignored outside the WAIT states.
- irq_o = DONE & IRQ_EN, registered. A W1C write to DONE drops irq_o on the next cycle.
- Simultaneous events:
  - A W1C of DONE in the same cycle hardware sets DONE: the set wins.
  - A START write that also changes IRQ_EN applies IRQ_EN first.
- Reset mid-transfer: host_req_o drops asynchronously and all state returns to its reset value. A pending bus response after reset is ignored.
- Throughput with zero-wait grants and rvalid one cycle after grant: 4 cycles per word.

Test Plan:
- Set SRC=0x100000, DST=0x100400, LEN=4, START. Expect 4 reads then 4 writes interleaved, DST words equal to SRC words, final SRC=0x100010, DST=0x100410, LEN=0, STATUS=0x2.
- Set LEN=0, START. Expect no host_req_o, DONE=1 one cycle later, and irq_o=1 if IRQ_EN.
- Random grant stalls of 0-5 cycles on 8 words. Expect host_addr_o/host_wdata_o stable while host_req_o && !host_gnt_i, and correct data.
- Return host_err_i on the read of word 2 of 5. Expect STATUS=0x6, SRC=start+8, LEN=3, no write issued for word 2.
- Write LEN while BUSY. Expect dev_err_o=1 and LEN unchanged. Write STATUS=0x2 at the hardware DONE set cycle: expect DONE stays 1.
- Assert rst_i during WR_REQ. Expect host_req_o=0 immediately, all registers 0, and a late host_rvalid_i ignored.
